// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers: occupancy codes and
// the default payload/control widths of each CPU stage boundary.
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // PC + instruction
    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 1;
    // PC + rs1 + rs2 + imm + rd
    localparam int IDEX_DATA_W  = 133;
    localparam int IDEX_CTRL_W  = 9;
    // ALU result + store data + rd
    localparam int EXMEM_DATA_W = 69;
    localparam int EXMEM_CTRL_W = 4;
    // load data + ALU result + rd
    localparam int MEMWB_DATA_W = 69;
    localparam int MEMWB_CTRL_W = 2;

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        logic [1:0] occ;
        case ({main_v, skid_v})
            2'b00:   occ = OCC_EMPTY;
            2'b11:   occ = OCC_TWO;
            default: occ = OCC_ONE;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+data+ctrl holding register. Clearing drops valid and control but
// keeps the payload, so the stage never presents stale control bits.
import pipe_pkg::*;

module pipe_slot #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, optional 2-entry
// skid buffer, flush-to-bubble, start gating and saturating back-pressure count.
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  bp_cnt_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and while start_i is low no
    // transfer takes place in either direction.
    logic              running, in_fire, out_fire;
    logic              main_load, main_clear, main_from_skid;
    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;

    assign running  = start_i & ~flush_i;
    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = main_valid & out_ready_i;

    assign main_d_data = main_from_skid ? skid_data : in_data_i;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl_i;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .valid  (main_valid),
        .data   (main_data),
        .ctrl   (main_ctrl)
    );

    generate
        if (SKID) begin : g_skid
            logic skid_load, skid_clear;

            // Ready only looks at registered skid state, cutting the
            // out_ready_i -> in_ready_o path.
            assign in_ready_o = start_i & ~rst_i & ~skid_valid;

            always_comb begin
                main_load      = 1'b0;
                main_clear     = flush_i;
                main_from_skid = 1'b0;
                skid_load      = 1'b0;
                skid_clear     = flush_i;
                if (running) begin
                    if (!main_valid) begin
                        main_load = in_fire;
                    end else if (out_fire) begin
                        if (skid_valid) begin
                            main_load      = 1'b1;
                            main_from_skid = 1'b1;
                            skid_clear     = 1'b1;
                        end else if (in_fire) begin
                            main_load = 1'b1;
                        end else begin
                            main_clear = 1'b1;
                        end
                    end else begin
                        skid_load = in_fire;
                    end
                end
            end

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_data (in_data_i),
                .d_ctrl (in_ctrl_i),
                .valid  (skid_valid),
                .data   (skid_data),
                .ctrl   (skid_ctrl)
            );
        end else begin : g_noskid
            assign in_ready_o = start_i & ~rst_i & (~main_valid | out_ready_i);
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;

            always_comb begin
                main_from_skid = 1'b0;
                main_load      = running & in_fire;
                main_clear     = flush_i | (running & ~in_fire & out_fire);
            end
        end
    endgenerate

    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;
    assign out_ctrl_o  = main_ctrl;
    assign occ_o       = occ_count(main_valid, skid_valid);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bp_cnt_o <= '0;
        end else if (running && main_valid && !out_ready_i && bp_cnt_o != {CNT_W{1'b1}}) begin
            bp_cnt_o <= bp_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid and a non-skid instance share one stimulus
// stream and are each compared against a capacity-limited FIFO reference model.
module tb_pipe_stage_reg;

    localparam int DW = 69;
    localparam int CW = 4;
    localparam int NW = 4;
    localparam int EW = DW + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          ir0, ov0, ir1, ov1;
    logic [DW-1:0] od0, od1;
    logic [CW-1:0] oc0, oc1;
    logic [1:0]    occ0, occ1;
    logic [NW-1:0] bp0, bp1;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(NW)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ir0), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0), .out_ctrl_o(oc0),
        .occ_o(occ0), .bp_cnt_o(bp0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(NW)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ir1), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1), .out_ctrl_o(oc1),
        .occ_o(occ1), .bp_cnt_o(bp1)
    );

    // scoreboard: expected {ctrl,data} in arrival order, one queue per instance
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int bpm[2];
    int vectors     = 0;
    int miscompares = 0;

    function automatic int q_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [EW-1:0] q_head(input int k);
        return (k == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    task automatic q_pop(input int k);
        if (k == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
    endtask

    task automatic q_push(input int k, input logic [EW-1:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic q_clear(input int k);
        if (k == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    task automatic chk(input string name, input int k, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Monitor: compare what the instance presents, then advance the model
    // across the coming rising edge (capacity 2 with skid, 1 without).
    task automatic check_dut(input int k, input logic ir, input logic ov, input logic [DW-1:0] od,
                             input logic [CW-1:0] oc, input logic [1:0] occ, input logic [NW-1:0] bp);
        int   n;
        logic exp_rdy, inf, ouf;
        n       = q_size(k);
        exp_rdy = start && !rst && ((k == 1) ? (n < 2) : (n == 0 || out_ready));
        chk("in_ready", k, 80'(ir), 80'(exp_rdy));
        if (rst) begin
            q_clear(k);
            bpm[k] = 0;
        end else begin
            chk("out_valid", k, 80'(ov), 80'(n > 0));
            chk("occ", k, 80'(occ), 80'(n));
            chk("bp_cnt", k, 80'(bp), 80'(bpm[k]));
            if (n > 0) chk("out_payload", k, 80'({oc, od}), 80'(q_head(k)));
            else       chk("out_ctrl_idle", k, 80'(oc), 80'(0));
            inf = in_valid && exp_rdy;
            ouf = (n > 0) && out_ready && start;
            if (flush) begin
                q_clear(k);
            end else if (start) begin
                if (n > 0 && !out_ready && bpm[k] < (2**NW - 1)) bpm[k]++;
                if (ouf) q_pop(k);
                if (inf) q_push(k, {in_ctrl, in_data});
            end
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, ir0, ov0, od0, oc0, occ0, bp0);
        check_dut(1, ir1, ov1, od1, oc1, occ1, bp1);
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic drive(input logic r, input logic s, input logic f, input logic v, input logic rdy,
                         input logic [DW-1:0] d, input logic [CW-1:0] c);
        @(posedge clk);
        #1;
        rst       = r;
        start     = s;
        flush     = f;
        in_valid  = v;
        out_ready = rdy;
        in_data   = d;
        in_ctrl   = c;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        drive(1, 1, 0, 0, 0, '0, '0);
        // first transfer with a known pattern
        drive(0, 1, 0, 1, 1, 69'h0AB, 4'b1011);
        repeat (2) drive(0, 1, 0, 0, 1, rnd_data(), 4'($urandom()));
        // stall: push A, B, C with downstream blocked, then release
        repeat (3) drive(0, 1, 0, 1, 0, rnd_data(), 4'($urandom()));
        repeat (3) drive(0, 1, 0, 0, 0, rnd_data(), 4'($urandom()));
        repeat (4) drive(0, 1, 0, 0, 1, rnd_data(), 4'($urandom()));
        // fill, then flush while offering C
        repeat (2) drive(0, 1, 0, 1, 0, rnd_data(), 4'($urandom()));
        drive(0, 1, 1, 1, 0, rnd_data(), 4'hF);
        repeat (2) drive(0, 1, 0, 0, 1, rnd_data(), 4'($urandom()));
        // start gating with out_ready toggling
        drive(0, 1, 0, 1, 0, rnd_data(), 4'($urandom()));
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, i[0], rnd_data(), 4'($urandom()));
        repeat (2) drive(0, 1, 0, 0, 1, rnd_data(), 4'($urandom()));
        // back-pressure counter saturation
        drive(0, 1, 0, 1, 0, rnd_data(), 4'($urandom()));
        repeat (20) drive(0, 1, 0, 0, 0, rnd_data(), 4'($urandom()));
        repeat (3) drive(0, 1, 0, 0, 1, rnd_data(), 4'($urandom()));
        // reset mid-transfer
        repeat (2) drive(0, 1, 0, 1, 0, rnd_data(), 4'($urandom()));
        drive(1, 1, 0, 1, 1, rnd_data(), 4'($urandom()));
        repeat (2) drive(0, 1, 0, 0, 1, rnd_data(), 4'($urandom()));
        // streaming with full throughput
        repeat (8) drive(0, 1, 0, 1, 1, rnd_data(), 4'($urandom()));
        drive(0, 1, 0, 1, 0, rnd_data(), 4'($urandom()));
        // randomized traffic
        repeat (800) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 6, rnd_data(), 4'($urandom()));
        end
        repeat (4) drive(0, 1, 0, 0, 1, rnd_data(), 4'($urandom()));
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register that generalises the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block.
- Carries an arbitrary data payload and control bundle with a valid/ready handshake in place of a bare stall input.
- Provides an optional 2-entry skid buffer, synchronous flush that inserts a bubble, start gating, and a saturating back-pressure counter.
- Instantiated between every pair of CPU pipeline stages.

Parameters:
- DATA_W, 69, payload width (e.g. ALU result 32 + store data 32 + rd address 5).
- CTRL_W, 4, control bundle width (e.g. RegWrite, MemtoReg, MemRead, MemWrite).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.
- CNT_W, 16, width of the back-pressure counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  CPU run enable; 0 freezes all state.
- flush_i  in  1  synchronous bubble insert.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept.
- in_data_i  in  DATA_W  upstream payload.
- in_ctrl_i  in  CTRL_W  upstream control bundle.
- out_valid_o  out  1  payload valid to downstream.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  registered payload.
- out_ctrl_o  out  CTRL_W  registered control; forced 0 when not valid.
- occ_o  out  2  entries held (0..2; max 1 when SKID=0).
- bp_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating.

Behaviour:
- Event definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Priority: rst_i > flush_i > start_i gating > handshake.
- Reset values: out_valid_o=0, out_data_o=0, out_ctrl_o=0, skid entry empty with contents 0, occ_o=0, bp_cnt_o=0. in_ready_o is 0 during the reset cycle and 1 afterwards once start_i=1.
- start_i=0:
  - No register changes (including bp_cnt_o).
  - in_ready_o=0.
  - Outputs hold their values.
  - out_fire is ignored.
- flush_i=1 (regardless of start_i):
  - Next cycle: out_valid_o=0, out_ctrl_o=0, skid emptied, occ_o=0.
  - out_data_o holds its value.
  - An in_fire in the same cycle is discarded.
  - bp_cnt_o is unchanged.
- SKID=0:
  - in_ready_o = start_i & (!out_valid_o | out_ready_i), combinational.
  - On in_fire, the main register loads next edge. Else on out_fire, out_valid_o clears.
  - Latency is 1 cycle; throughput is 1 per cycle.
- SKID=1:
  - in_ready_o = start_i & !skid_valid; skid_valid is registered.
  - Main empty: in_fire loads main.
  - Main full, out_fire, skid full: main <= skid; skid empties.
  - Main full, out_fire, skid empty: in_fire loads main; otherwise main empties.
  - Main full, no out_fire: in_fire loads skid.
  - Order is strictly FIFO. Latency is 1 cycle when unstalled. No combinational path from out_ready_i to in_ready_o.
- Output data/ctrl:
  - Change only when main loads; hold otherwise.
  - out_ctrl_o is cleared whenever main becomes empty (never presents stale control).
- occ_o = main_valid + skid_valid.
- bp_cnt_o increments by 1 each running cycle (start_i=1, no flush) with out_valid_o & !out_ready_i. It saturates at 2^CNT_W-1 and does not wrap.
- rst_i mid-transfer drops all held entries with no output pulse.

Decomposition:
- Shared package pipe_pkg: OCC_EMPTY/OCC_ONE/OCC_TWO constants, and default DATA_W/CTRL_W per stage (IFID, IDEX, EXMEM, MEMWB).
- One sub-module, pipe_slot: a single valid+data+ctrl register with load/clear, instantiated as main and skid.

Test Plan:
- Reset then start_i=1; in_valid_i=1, data=0x...0AB, ctrl=4'b1011, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=0x...0AB, out_ctrl_o=4'b1011, bp_cnt_o=0.
- SKID=1, out_ready_i=0, push A then B -> occ_o=2, in_ready_o=0, bp_cnt_o counts 1,2,…; raise out_ready_i -> A then B on consecutive cycles, in_ready_o returns to 1.
- occ_o=2 plus flush_i=1 while in_valid_i=1 with C -> next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0; C never appears.
- start_i=0 for 3 cycles with out_ready_i toggling -> out_*/occ_o/bp_cnt_o unchanged, in_ready_o=0.
- CNT_W=4, hold out_valid_o=1, out_ready_i=0 for 20 cycles -> bp_cnt_o saturates at 15.
- SKID=0, streaming with out_ready_i=1 -> one item per cycle; drop out_ready_i -> in_ready_o=0 in the same cycle.
